hex_display_mux: RTL and testbench
==================================

Name: hex_display_mux

Overview:
Parametrised time-multiplexed hexadecimal seven-segment driver: NUM_DIGITS nibbles, one digit lit per refresh slot, 8 segment lines shared across digits.
Next generation of the fixed 32-bit/8-digit display driver. Adds:
- a tear-free load handshake;
- PWM brightness;
- leading-zero blanking;
- per-digit decimal points;
- selectable pin polarities.
Sits between the free-running system counter domain and the board's digit drains/segment pins; runs on the main clock (no derived clocks).

Parameters:
- NUM_DIGITS, 8, number of digits. Range 2..16.
- REFRESH_DIV, 16, log2 of clocks per digit slot. Must be >= BRIGHT_BITS+1.
- BRIGHT_BITS, 4, brightness resolution in bits.
- DRAIN_ACTIVE_LOW, 1, 1 = drains[i] low selects digit i.
- SEG_ACTIVE_LOW, 0, 1 = leds bits low light a segment.

Ports:
- CLK, in, 1, system clock.
- RST_N, in, 1, asynchronous active-low reset.
- data, in, 4*NUM_DIGITS, hex value; nibble i drives digit i, digit 0 least significant.
- dp, in, NUM_DIGITS, decimal point per digit.
- load, in, 1, single-cycle strobe capturing data/dp.
- pending, out, 1, captured value not yet on display.
- brightness, in, BRIGHT_BITS, on-time; 0 = dark.
- blank_lz, in, 1, enable leading-zero blanking.
- drains, out, NUM_DIGITS, digit select.
- leds, out, 8, segments: leds[6:0]=g..a, leds[7]=dp.
- frame_done, out, 1, one-cycle pulse at end of each full scan.

Behaviour:
- Reset (async assert, sync release): prescaler=0, digit index=0, shadow and display registers=0, pending=0, frame_done=0. drains all inactive and leds all unlit, polarity applied.
- Prescaler: REFRESH_DIV-bit free-running counter. Slot end = prescaler all-ones. At slot end the digit index increments, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary: slot end with index == NUM_DIGITS-1. frame_done pulses high in the following cycle, aligned with the index becoming 0.
- Load handshake:
  - load high: data/dp captured into shadow, pending=1.
  - A further load while pending overwrites the shadow; last load wins, nothing queued.
  - At a frame boundary with pending=1: shadow copied to display, pending=0.
  - load coincident with a frame boundary: the new data goes straight to display, pending stays 0.
  - The display register never changes mid-frame.
- Decode of the display nibble for the current index, active-high form: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. leds[7]=dp bit. Inverted when SEG_ACTIVE_LOW.
- Leading-zero blanking (blank_lz=1): digit i (i>0) has segments [6:0] unlit if it and every higher nibble are 0. Digit 0 is never blanked. dp is unaffected.
- Drain on-time: the drain for the current index is active iff prescaler != 0 and prescaler[REFRESH_DIV-1 -: BRIGHT_BITS] < brightness.
  - Cycle 0 of every slot is dead time with all drains inactive (anti-ghosting).
  - All other drains are always inactive.
- Output registering: drains and leds are registered, 1 cycle latency from prescaler/index state. Segments change only while drains are inactive.
- Brightness and blank_lz are sampled live; a change takes effect at the next cycle.

Optional Feature:
HEX_MUX_LAMP_TEST_EN: adds input port lamp_test (1 bit).
- lamp_test=1: every digit shows all 8 segments lit, overriding decode, blanking and dp. Scan, PWM and the load handshake continue unchanged.
- Macro undefined: the port does not exist and the behaviour is as above.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BRIGHT_BITS=2, defaults otherwise; slot = 16 clocks, frame = 64 clocks.
1. Reset mid-scan: assert RST_N=0 at a random cycle -> drains=4'hF and leds=8'h00 asynchronously; after release the first frame_done pulse comes 64 cycles later.
2. Scan/decode: load data=16'h1A2F, dp=4'b0100, brightness=3, then wait a frame -> digit0 leds=71, digit1 leds=5B, digit2 leds=F7, digit3 leds=06. Each drain is low for cycles 1..11 of its slot (prescaler != 0 and top bits < 3), high for cycles 0 and 12..15.
3. Tear-free load: pulse load=16'h0001 then load=16'h0002 mid-frame -> pending=1, display unchanged until the boundary, then shows 0002 and pending=0. Separately, load on the exact boundary cycle -> displayed immediately, pending never set.
4. Brightness edges: brightness=0 -> drains never active over a frame. brightness=1 -> each drain active for 3 cycles per slot.
5. Blanking: data=16'h0070, blank_lz=1 -> digit3 and digit2 segments unlit, digit1=07, digit0=3F. data=16'h0000 -> only digit0 lit (3F). blank_lz=0 -> all digits shown.
6. With HEX_MUX_LAMP_TEST_EN and lamp_test=1 -> leds=8'hFF on every digit, drain PWM unchanged.

Source files
------------

// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed hexadecimal seven-segment driver.
// One digit is lit per refresh slot; the 8 segment lines are shared by all
// digits. A shadow register plus a pending flag makes loads tear-free:
// the displayed value only changes at a frame boundary.
// Optional feature macro: HEX_MUX_LAMP_TEST_EN adds a lamp_test input that
// lights every segment of every digit while the scan keeps running.
module hex_display_mux #(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 16,
    parameter int BRIGHT_BITS      = 4,
    parameter int DRAIN_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 0
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic                    pending,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    blank_lz,
`ifdef HEX_MUX_LAMP_TEST_EN
    input  logic                    lamp_test,
`endif
    output logic [NUM_DIGITS-1:0]   drains,
    output logic [7:0]              leds,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DRAINS_OFF = {NUM_DIGITS{DRAIN_ACTIVE_LOW != 0}};
    localparam logic [7:0]            LEDS_OFF   = {8{SEG_ACTIVE_LOW != 0}};

    logic [REFRESH_DIV-1:0]  prescaler;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic                    slot_end;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    higher_nz;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    drive_on;
    logic [7:0]              seg_on;
    logic [NUM_DIGITS-1:0]   drain_on;
    logic [NUM_DIGITS-1:0]   drains_next;
    logic [7:0]              leds_next;

    // Active-high segment pattern (g..a) for one hex nibble.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign slot_end  = &prescaler;
    assign frame_end = slot_end && (digit_idx == LAST_IDX);

    // Free-running slot prescaler, digit index stepping and end-of-frame pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            frame_done <= frame_end;
            if (slot_end) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Load handshake: loads land in the shadow, display only moves at a frame boundary.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            pending     <= 1'b0;
        end else if (load) begin
            shadow_data <= data;
            shadow_dp   <= dp;
            if (frame_end) begin
                disp_data <= data;
                disp_dp   <= dp;
                pending   <= 1'b0;
            end else begin
                pending   <= 1'b1;
            end
        end else if (frame_end && pending) begin
            disp_data <= shadow_data;
            disp_dp   <= shadow_dp;
            pending   <= 1'b0;
        end
    end

    // Select the current digit's nibble/dp and decide whether it is a leading zero.
    always_comb begin
        higher_nz  = 1'b0;
        lead_zero  = '0;
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_nz    = higher_nz | (|disp_data[4*i +: 4]);
            lead_zero[i] = !higher_nz;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nibble = disp_data[4*i +: 4];
                cur_dp     = disp_dp[i];
                cur_blank  = blank_lz && (i != 0) && lead_zero[i];
            end
        end
    end

    // Segment pattern and PWM drain select, then pin polarity.
    always_comb begin
        seg_on = {cur_dp, cur_blank ? 7'h00 : seg7_decode(cur_nibble)};
`ifdef HEX_MUX_LAMP_TEST_EN
        if (lamp_test) begin
            seg_on = 8'hFF;
        end
`endif
        drive_on = (prescaler != '0) &&
                   (prescaler[REFRESH_DIV-1 -: BRIGHT_BITS] < brightness);
        drain_on = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            drain_on[i] = drive_on && (digit_idx == IDX_W'(i));
        end
        drains_next = (DRAIN_ACTIVE_LOW != 0) ? ~drain_on : drain_on;
        leds_next   = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
    end

    // Registered pin outputs; the slot's dead cycle hides the segment change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drains <= DRAINS_OFF;
            leds   <= LEDS_OFF;
        end else begin
            drains <= drains_next;
            leds   <= leds_next;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// tb_hex_display_mux: randomized and directed bench for hex_display_mux
// (4 digits, 16-clock slots, 2-bit brightness). Expected pin values come
// from a cycle-count reference model of the scan and load handshake.
module tb_hex_display_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BB = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic        pending;
    logic [1:0]  brightness;
    logic        blank_lz;
    logic [3:0]  drains;
    logic [7:0]  leds;
    logic        frame_done;
`ifdef HEX_MUX_LAMP_TEST_EN
    logic        lamp_drive;
`endif

    always #5 CLK = ~CLK;

    hex_display_mux #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BRIGHT_BITS(BB),
        .DRAIN_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .data(data),
        .dp(dp),
        .load(load),
        .pending(pending),
        .brightness(brightness),
        .blank_lz(blank_lz),
`ifdef HEX_MUX_LAMP_TEST_EN
        .lamp_test(lamp_drive),
`endif
        .drains(drains),
        .leds(leds),
        .frame_done(frame_done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: cycles since reset release plus handshake registers.
    int unsigned cyc;
    logic [15:0] m_shadow;
    logic [3:0]  m_shadow_dp;
    logic [15:0] m_disp;
    logic [3:0]  m_disp_dp;
    logic        m_pending;

    logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        cyc         = 0;
        m_shadow    = '0;
        m_shadow_dp = '0;
        m_disp      = '0;
        m_disp_dp   = '0;
        m_pending   = 1'b0;
    endtask

    // One clock: drive inputs, predict the post-edge pins, step the model, compare.
    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic [3:0] p,
                                 input logic [1:0] br, input logic blz);
        int unsigned ps;
        int unsigned ix;
        logic        boundary;
        logic [3:0]  exp_drains;
        logic [7:0]  exp_leds;
        logic [15:0] upper;
        @(negedge CLK);
        load       = ld;
        data       = d;
        dp         = p;
        brightness = br;
        blank_lz   = blz;
        ps       = cyc % 16;
        ix       = (cyc / 16) % 4;
        boundary = ((cyc % 64) == 63);
        exp_drains = 4'hF;
        if (ps != 0 && (ps / 4) < br) exp_drains[ix] = 1'b0;
        upper = m_disp >> (4 * ix);
        exp_leds[6:0] = seg_table[upper[3:0]];
        if (blz && ix > 0 && upper == 16'h0) exp_leds[6:0] = 7'h00;
        exp_leds[7] = m_disp_dp[ix];
`ifdef HEX_MUX_LAMP_TEST_EN
        if (lamp_drive) exp_leds = 8'hFF;
`endif
        if (ld) begin
            m_shadow    = d;
            m_shadow_dp = p;
            if (boundary) begin
                m_disp    = d;
                m_disp_dp = p;
                m_pending = 1'b0;
            end else begin
                m_pending = 1'b1;
            end
        end else if (boundary && m_pending) begin
            m_disp    = m_shadow;
            m_disp_dp = m_shadow_dp;
            m_pending = 1'b0;
        end
        cyc++;
        @(posedge CLK);
        #1;
        checkOutput("drains", 32'(drains), 32'(exp_drains));
        checkOutput("leds", 32'(leds), 32'(exp_leds));
        checkOutput("pending", 32'(pending), 32'(m_pending));
        checkOutput("frame_done", 32'(frame_done), 32'(boundary));
    endtask

    task automatic runCycles(input int n, input logic [1:0] br, input logic blz);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 4'h0, br, blz);
    endtask

    task automatic runUntilPhase(input int unsigned ph, input logic [1:0] br, input logic blz);
        while ((cyc % 64) != ph) applyStimulus(1'b0, 16'h0, 4'h0, br, blz);
    endtask

    // Assert reset between edges, check the async outputs, release just after a posedge.
    task automatic doReset(input int hold);
        @(negedge CLK);
        load = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("rst_drains", 32'(drains), 32'h0000_000F);
        checkOutput("rst_leds", 32'(leds), 32'h0000_0000);
        checkOutput("rst_pending", 32'(pending), 32'h0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
        repeat (hold) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        modelReset();
    endtask

    task automatic checkFirstFrame();
        int count;
        count = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 16'h0, 4'h0, 2'd3, 1'b0);
            count++;
            if (frame_done) break;
        end
        checkOutput("first_frame_latency", 32'(count), 32'd64);
    endtask

    initial begin
        RST_N      = 1'b0;
        load       = 1'b0;
        data       = '0;
        dp         = '0;
        brightness = '0;
        blank_lz   = 1'b0;
`ifdef HEX_MUX_LAMP_TEST_EN
        lamp_drive = 1'b0;
`endif
        modelReset();

        doReset(3);
        checkFirstFrame();

        // Scan and decode of 1A2F with the dp on digit 2.
        applyStimulus(1'b1, 16'h1A2F, 4'b0100, 2'd3, 1'b0);
        runCycles(140, 2'd3, 1'b0);

        // Two loads mid-frame: last wins, shown at the boundary.
        runUntilPhase(20, 2'd3, 1'b0);
        applyStimulus(1'b1, 16'h0001, 4'b0000, 2'd3, 1'b0);
        runCycles(3, 2'd3, 1'b0);
        applyStimulus(1'b1, 16'h0002, 4'b0001, 2'd3, 1'b0);
        runCycles(80, 2'd3, 1'b0);

        // Load exactly on the boundary cycle goes straight to display.
        runUntilPhase(63, 2'd3, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 4'b1010, 2'd3, 1'b0);
        runCycles(70, 2'd3, 1'b0);

        // Brightness extremes.
        runCycles(70, 2'd0, 1'b0);
        runCycles(70, 2'd1, 1'b0);

        // Leading-zero blanking.
        applyStimulus(1'b1, 16'h0070, 4'b0000, 2'd3, 1'b1);
        runCycles(140, 2'd3, 1'b1);
        applyStimulus(1'b1, 16'h0000, 4'b1000, 2'd3, 1'b1);
        runCycles(140, 2'd3, 1'b1);
        runCycles(70, 2'd3, 1'b0);

`ifdef HEX_MUX_LAMP_TEST_EN
        lamp_drive = 1'b1;
        applyStimulus(1'b1, 16'h1234, 4'b0001, 2'd2, 1'b1);
        runCycles(140, 2'd2, 1'b1);
        lamp_drive = 1'b0;
`endif

        // Random traffic with a reset dropped mid-scan.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 600; i++) begin
                applyStimulus(($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom),
                              2'($urandom), 1'($urandom));
            end
            runCycles(int'($urandom_range(1, 150)), 2'($urandom), 1'($urandom));
            doReset(int'($urandom_range(1, 4)));
            checkFirstFrame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
